// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: synchronises N_KEY raw active-low buttons, filters bounce
// with a DEPTH-sample window advanced on rising edges of clk_debounce, and emits a
// clean per-key level plus a one-cycle press pulse.
// Optional feature macro: KEY_AUTOREPEAT_EN adds auto-repeat pulses while a key is held.
module key_debounce_pulse #(
  parameter int unsigned N_KEY        = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned HOLD_TICKS   = 32,
  parameter int unsigned REPEAT_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_debounce,
  input  logic [N_KEY-1:0] key_n,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_pulse,
  output logic             key_any
);

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned HoldMax = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned CntW    = $clog2(HoldMax + 1);
  localparam logic [CntW-1:0] HoldCmp   = CntW'(HOLD_TICKS);
  localparam logic [CntW-1:0] RepeatCmp = CntW'(REPEAT_TICKS);
`endif

  typedef enum logic [1:0] {
    StReleased,
    StPressed
`ifdef KEY_AUTOREPEAT_EN
    , StRepeat
`endif
  } state_e;

  logic [N_KEY-1:0] sync1_q, sync2_q;
  logic [N_KEY-1:0] s;
  logic             dbc_q;
  logic             tick;
  logic [DEPTH-1:0] sh_q [N_KEY];
  logic [DEPTH-1:0] w    [N_KEY];
  logic [N_KEY-1:0] all_ones, all_zeros;
  state_e           state_q [N_KEY];
  state_e           state_d [N_KEY];
  logic [N_KEY-1:0] pulse_q, pulse_d;
`ifdef KEY_AUTOREPEAT_EN
  logic [CntW-1:0]  hold_q   [N_KEY];
  logic [CntW-1:0]  hold_d   [N_KEY];
  logic [CntW-1:0]  hold_inc [N_KEY];
`endif

  // Two-flop synchroniser; idle (released) value is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Delayed copy of the divider output; reset to 1 so a level high at release is no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbc_q <= 1'b1;
    end else begin
      dbc_q <= clk_debounce;
    end
  end

  assign tick = clk_debounce & ~dbc_q;

  // Candidate window including the current sample, and its all-ones/all-zeros decode.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      w[i]         = {sh_q[i][DEPTH-2:0], s[i]};
      all_ones[i]  = &w[i];
      all_zeros[i] = ~|w[i];
`ifdef KEY_AUTOREPEAT_EN
      hold_inc[i]  = hold_q[i] + 1'b1;
`endif
    end
  end

  // Sample window shifts only on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEY; i++) sh_q[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_KEY; i++) sh_q[i] <= w[i];
    end
  end

  // Per-key state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEY; i++) state_q[i] <= StReleased;
    end else begin
      for (int i = 0; i < N_KEY; i++) state_q[i] <= state_d[i];
    end
  end

  // Next-state: only a tick moves a key; mixed windows hold the state (hysteresis).
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      state_d[i] = state_q[i];
      if (tick) begin
        case (state_q[i])
          StReleased: begin
            if (all_ones[i]) state_d[i] = StPressed;
          end
          StPressed: begin
            if (all_zeros[i]) state_d[i] = StReleased;
`ifdef KEY_AUTOREPEAT_EN
            else if (hold_inc[i] == HoldCmp) state_d[i] = StRepeat;
`endif
          end
`ifdef KEY_AUTOREPEAT_EN
          StRepeat: begin
            if (all_zeros[i]) state_d[i] = StReleased;
          end
`endif
          default: state_d[i] = StReleased;
        endcase
      end
    end
  end

  // Outputs: pulse request and hold counter update for the coming edge.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      pulse_d[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      hold_d[i]  = hold_q[i];
`endif
      if (tick) begin
        case (state_q[i])
          StReleased: begin
            if (all_ones[i]) begin
              pulse_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              hold_d[i]  = '0;
`endif
            end
          end
`ifdef KEY_AUTOREPEAT_EN
          StPressed: begin
            if (all_zeros[i]) begin
              hold_d[i] = '0;
            end else if (hold_inc[i] == HoldCmp) begin
              pulse_d[i] = 1'b1;
              hold_d[i]  = '0;
            end else begin
              hold_d[i] = hold_inc[i];
            end
          end
          StRepeat: begin
            if (all_zeros[i]) begin
              hold_d[i] = '0;
            end else if (hold_inc[i] == RepeatCmp) begin
              pulse_d[i] = 1'b1;
              hold_d[i]  = '0;
            end else begin
              hold_d[i] = hold_inc[i];
            end
          end
`endif
          default: pulse_d[i] = 1'b0;
        endcase
      end
    end
  end

  // Pulse register; tick is a single-cycle event so each pulse lasts one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Hold/repeat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEY; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEY; i++) hold_q[i] <= hold_d[i];
    end
  end
`endif

  // Level is any non-released state; key_any is derived from registered state.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) key_level[i] = (state_q[i] != StReleased);
    key_pulse = pulse_q;
    key_any   = |key_level;
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: random stimulus compared cycle by cycle against a
// behavioural model built from sample run-lengths and tick counts since acceptance.
module tb_key_debounce_pulse;
  localparam int unsigned N_KEY        = 4;
  localparam int          DEPTH        = 4;
  localparam int          HOLD_TICKS   = 32;
  localparam int          REPEAT_TICKS = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clk_debounce;
  logic [N_KEY-1:0] key_n;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] key_pulse;
  logic             key_any;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce_pulse #(
    .N_KEY       (N_KEY),
    .DEPTH       (DEPTH),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_debounce(clk_debounce),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_pulse   (key_pulse),
    .key_any     (key_any)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N_KEY-1:0] m_kn1, m_kn2;
  logic             m_dbc;
  logic [N_KEY-1:0] exp_level, exp_pulse;
  int               ones_run  [N_KEY];
  int               zeros_run [N_KEY];
  int               since     [N_KEY];
  int unsigned      cyc = 0;

  task automatic model_reset();
    m_kn1     = '1;
    m_kn2     = '1;
    m_dbc     = 1'b1;
    exp_level = '0;
    exp_pulse = '0;
    for (int k = 0; k < N_KEY; k++) begin
      ones_run[k]  = 0;
      zeros_run[k] = DEPTH;
      since[k]     = 0;
    end
  endtask

  // Advance one clk: model what the DUT did at the posedge, then move clk_debounce.
  task automatic step();
    logic s;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_pulse = '0;
      if (clk_debounce && !m_dbc) begin
        for (int k = 0; k < N_KEY; k++) begin
          s = ~m_kn2[k];
          if (s) begin
            ones_run[k]++;
            zeros_run[k] = 0;
          end else begin
            zeros_run[k]++;
            ones_run[k] = 0;
          end
          if (!exp_level[k] && ones_run[k] >= DEPTH) begin
            exp_level[k] = 1'b1;
            exp_pulse[k] = 1'b1;
            since[k]     = 0;
          end else if (exp_level[k] && zeros_run[k] >= DEPTH) begin
            exp_level[k] = 1'b0;
          end else if (exp_level[k]) begin
            since[k]++;
`ifdef KEY_AUTOREPEAT_EN
            if (since[k] == HOLD_TICKS ||
                (since[k] > HOLD_TICKS && (since[k] - HOLD_TICKS) % REPEAT_TICKS == 0))
              exp_pulse[k] = 1'b1;
`endif
          end
        end
      end
      m_dbc = clk_debounce;
      m_kn2 = m_kn1;
      m_kn1 = key_n;
    end
    cyc++;
    clk_debounce = ((cyc % 16) < 8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = '1;
    model_reset();
    #1;
    n_cmp++;
    if (key_level !== 4'b0 || key_pulse !== 4'b0 || key_any !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values level=%b pulse=%b any=%b required all 0",
               key_level, key_pulse, key_any);
    end
    repeat (4) begin
      step();
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL reset_hold t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    rst_n = 1'b1;
    repeat (100) begin
      step();
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL reset_idle t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    repeat ($urandom_range(0, 15)) step();
    key_n[0] = 1'b0;
    repeat (120) begin
      step();
      if (key_pulse[0]) pulses++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL clean_press t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (pulses != 1 || key_level[0] !== 1'b1 || key_any !== 1'b1) begin
      n_err++;
      $display("FAIL clean_press_count pulses=%0d level0=%b any=%b required 1/1/1",
               pulses, key_level[0], key_any);
    end
  endtask

  task automatic test_bounce();
    int pulses_bounce = 0;
    int pulses_after  = 0;
    int elapsed       = 0;
    int seg;
    while (elapsed < 100) begin
      seg = $urandom_range(6, 10);
      key_n[1] = ~key_n[1];
      repeat (seg) begin
        step();
        elapsed++;
        if (key_pulse[1]) pulses_bounce++;
        n_cmp++;
        if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
          n_err++;
          $display("FAIL bounce t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                   key_level, exp_level, key_pulse, exp_pulse, key_any);
        end
      end
    end
    key_n[1] = 1'b0;
    repeat (100) begin
      step();
      if (key_pulse[1]) pulses_after++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL bounce_settle t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (pulses_bounce != 0 || pulses_after != 1) begin
      n_err++;
      $display("FAIL bounce_count during=%0d after=%0d required 0/1",
               pulses_bounce, pulses_after);
    end
  endtask

  task automatic test_release_glitch();
    int pulses = 0;
    int drops  = 0;
    key_n = '1;
    repeat (100) step();
    key_n[0] = 1'b0;
    repeat (100) step();
    key_n[0] = 1'b1;
    repeat (48) begin
      step();
      if (key_pulse[0]) pulses++;
      if (!key_level[0]) drops++;
    end
    key_n[0] = 1'b0;
    repeat (100) begin
      step();
      if (key_pulse[0]) pulses++;
      if (!key_level[0]) drops++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL glitch t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (pulses != 0 || drops != 0) begin
      n_err++;
      $display("FAIL glitch_hold pulses=%0d level_drops=%0d required 0/0", pulses, drops);
    end
    key_n[0] = 1'b1;
    repeat (100) begin
      step();
      if (key_pulse[0]) pulses++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL release t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (pulses != 0 || key_level[0] !== 1'b0) begin
      n_err++;
      $display("FAIL release_final pulses=%0d level0=%b required 0/0", pulses, key_level[0]);
    end
  endtask

  task automatic test_simultaneous();
    int all_cycles  = 0;
    int any_cycles  = 0;
    key_n = '1;
    repeat (100) step();
    repeat ($urandom_range(0, 15)) step();
    key_n = '0;
    repeat (100) begin
      step();
      if (key_pulse == 4'b1111) all_cycles++;
      if (key_pulse != 4'b0000) any_cycles++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL simultaneous t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (all_cycles != 1 || any_cycles != 1) begin
      n_err++;
      $display("FAIL simultaneous_count full=%0d nonzero=%0d required 1/1",
               all_cycles, any_cycles);
    end
  endtask

  task automatic test_reset_mid_hold();
    int pulses = 0;
    n_cmp++;
    if (key_level[2] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_hold_pre level2=%b required 1", key_level[2]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (key_level !== 4'b0 || key_pulse !== 4'b0 || key_any !== 1'b0) begin
      n_err++;
      $display("FAIL mid_hold_async level=%b pulse=%b any=%b required all 0",
               key_level, key_pulse, key_any);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (120) begin
      step();
      if (key_pulse[2]) pulses++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL mid_hold_after t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL mid_hold_repress pulses=%0d required 1", pulses);
    end
  endtask

  task automatic test_auto_repeat();
    int pulses   = 0;
    int required;
`ifdef KEY_AUTOREPEAT_EN
    required = 5;
`else
    required = 1;
`endif
    key_n = '1;
    repeat (100) step();
    key_n[3] = 1'b0;
    repeat (1000) begin
      step();
      if (key_pulse[3]) pulses++;
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL auto_repeat t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
    n_cmp++;
    if (pulses != required) begin
      n_err++;
      $display("FAIL auto_repeat_count pulses=%0d required %0d", pulses, required);
    end
    key_n[3] = 1'b1;
    repeat (120) step();
  endtask

  task automatic test_random();
    int run [N_KEY];
    for (int k = 0; k < N_KEY; k++) run[k] = 0;
    repeat (4000) begin
      for (int k = 0; k < N_KEY; k++) begin
        if (run[k] == 0) begin
          key_n[k] = $urandom_range(0, 1);
          run[k]   = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 200)
                                                 : $urandom_range(1, 40);
        end
        run[k]--;
      end
      step();
      n_cmp++;
      if (key_level !== exp_level || key_pulse !== exp_pulse || key_any !== (|exp_level)) begin
        n_err++;
        $display("FAIL random t=%0t level=%b/%b pulse=%b/%b any=%b", $time,
                 key_level, exp_level, key_pulse, exp_pulse, key_any);
      end
    end
  endtask

  initial begin
    clk_debounce = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid_hold();
    test_auto_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
